vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM between the pixel fetcher (video) and the CPU.
//  Video has absolute priority so the beam never misses a fetch.
//  The CPU is served in cycles where video does not request, such as borders and blanking.
//  Sits between the sync-generator-driven fetch logic, the CPU bus bridge and the VRAM macro.
// PARAMETERS
//  ADDR_W   14  VRAM word-address width
//  DATA_W   8   VRAM data width
//  STALL_W  8   width of the saturating CPU stall counter
// PORTS
//  clk          in   1        system clock (pixel clock domain)
//  reset        in   1        asynchronous, active-high reset
//  vid_req      in   1        video fetch request, this cycle
//  vid_addr     in   ADDR_W   video fetch address
//  vid_valid    out  1        vid_data valid (one cycle after a vid_req cycle)
//  vid_data     out  DATA_W   fetched video data
//  cpu_req      in   1        CPU request; held high with stable addr/we/wdata until cpu_ack
//  cpu_we       in   1        1 = write, 0 = read
//  cpu_addr     in   ADDR_W   CPU address
//  cpu_wdata    in   DATA_W   CPU write data
//  cpu_ack      out  1        one-cycle completion pulse
//  cpu_rdata    out  DATA_W   read data, valid while cpu_ack=1 for reads
//  cpu_stall    out  STALL_W  cycles the current/last CPU request waited, saturating
//  mem_addr     out  ADDR_W   RAM address (combinational mux)
//  mem_we       out  1        RAM write enable (combinational)
//  mem_wdata    out  DATA_W   RAM write data
//  mem_rdata    in   DATA_W   RAM read data, 1-cycle latency after address
// BEHAVIOUR
//  - Reset (async) values: vid_valid=0, vid_data=0, cpu_ack=0, cpu_rdata=0, cpu_stall=0.
//  - Reset also forces the FSM to IDLE and clears the write buffer.
//  - Reset mid-access drops the access with no ack; mem_we=0 while reset=1.
//  - Port mux per cycle: vid_req=1 -> mem_addr=vid_addr, mem_we=0.
//  - Otherwise, when the FSM issues a CPU access -> mem_* = cpu_*.
//  - Otherwise mem_we=0 and mem_addr=vid_addr.
//  - Video: vid_valid(N+1)=vid_req(N); vid_data(N+1)=mem_rdata. Latency 1, no backpressure.
//  - CPU FSM states: IDLE, ISSUE, ACK.
//    - IDLE:  cpu_req=1 and vid_req=0 -> issue this cycle, go to ACK.
//    - IDLE:  cpu_req=1 and vid_req=1 -> go to ISSUE and increment cpu_stall.
//    - ISSUE: issues on the first cycle with vid_req=0, then goes to ACK. Each blocked cycle increments cpu_stall.
//    - ACK:   cpu_ack=1 and cpu_rdata=mem_rdata (reads). Never issues in this cycle. Returns to IDLE.
//    - A req still high in the ACK cycle is not re-served. Peak CPU throughput is 1 access per 2 cycles.
//  - cpu_stall clears to 0 on each IDLE->issue/ISSUE entry.
//  - cpu_stall holds its final value after ack and saturates at all-ones.
//  - Simultaneous vid_req and cpu_req: video always wins. CPU can starve indefinitely under continuous vid_req.
//  - Address arithmetic: none; addresses pass through unmodified. No wrap logic.
// CONFIGURATION
//  Macro VRAM_WRITE_BUFFER_EN:
//  - Defined: adds a one-entry posted-write buffer.
//    - CPU write in IDLE with buffer empty: captured, cpu_ack next cycle regardless of vid_req.
//    - The buffer retires on the first cycle with vid_req=0; buffer retire has priority over new CPU issues.
//    - CPU write with buffer full waits until drained.
//    - CPU read waits until the buffer is empty, which preserves read-after-write order.
//    - cpu_stall counts only cycles the CPU is actually held.
//  - Undefined: no buffer; all CPU accesses use the IDLE/ISSUE/ACK path above.
// STRUCTURE
//  - Package vram_pkg: default ADDR_W/DATA_W localparams, FSM state typedef (IDLE/ISSUE/ACK), stall saturate constant.
//  - Sub-module vram_wbuf: posted-write buffer holding addr/data/valid.
//    - Interface: load, retire, full. Instantiated only under VRAM_WRITE_BUFFER_EN.
//  - Top level: the mux, the video pipeline register and the CPU FSM.
// TESTING
//  1. Video only: vid_req=1 at cycles 10..13, addr 0x100..0x103, RAM preloaded with addr[7:0].
//     -> vid_valid at cycles 11..14, data 0x00..0x03.
//  2. CPU write then read, no video: write 0x2A@0x0040, then read 0x0040.
//     -> each acked 2 cycles after req; cpu_rdata=0x2A; cpu_stall=0.
//  3. Contention: vid_req high cycles 0..4, cpu read issued cycle 0.
//     -> CPU access on cycle 5, cpu_ack cycle 6, cpu_stall=5, all 5 video fetches valid.
//  4. Stall saturation: vid_req high 300 cycles with cpu_req pending.
//     -> cpu_stall=255; ack follows 2 cycles after vid_req drops.
//  5. Async reset asserted mid-ISSUE: outputs 0 immediately, no cpu_ack, mem_we=0; FSM in IDLE after release.
//  6. VRAM_WRITE_BUFFER_EN: write 0x55@0x10 during vid_req=1.
//     -> ack next cycle; a following read of 0x10 waits for drain, returns 0x55.

Source files
------------

// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the VRAM arbiter slice: default bus widths, the CPU
// access FSM state type and the saturation value of the CPU stall counter.
// No ports (package).
// ----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_ADDR_W  = 14;
    localparam int VRAM_DATA_W  = 8;
    localparam int VRAM_STALL_W = 8;

    // Stall counter stops here instead of wrapping back to a small value
    localparam logic [VRAM_STALL_W-1:0] VRAM_STALL_SAT = {VRAM_STALL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } cpu_state_e;

endpackage : vram_pkg

// File: rtl/vram_arbiter_if.sv
// ----------------------------------------------------------------------------
// vram_arbiter_if
// Groups the three buses around the arbiter: video fetch port, CPU bridge port
// and the single-port VRAM macro port.
//   slave  : the arbiter side (takes requests, drives RAM and responses)
//   master : the environment side (fetcher, CPU bridge, RAM macro)
// Signals:
//   vid_req/vid_addr -> ; vid_valid/vid_data <-
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> ; cpu_ack/cpu_rdata/cpu_stall <-
//   mem_addr/mem_we/mem_wdata <- ; mem_rdata ->
// ----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W  = vram_pkg::VRAM_ADDR_W,
    parameter int DATA_W  = vram_pkg::VRAM_DATA_W,
    parameter int STALL_W = vram_pkg::VRAM_STALL_W
);
    logic               vid_req;
    logic [ADDR_W-1:0]  vid_addr;
    logic               vid_valid;
    logic [DATA_W-1:0]  vid_data;

    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_ack;
    logic [DATA_W-1:0]  cpu_rdata;
    logic [STALL_W-1:0] cpu_stall;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata, cpu_stall,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata, cpu_stall,
               mem_addr, mem_we, mem_wdata
    );

endinterface : vram_arbiter_if

// File: rtl/vram_wbuf.sv
// ----------------------------------------------------------------------------
// vram_wbuf
// One-entry posted-write buffer. A CPU write is captured on load and held
// until retire empties it into the RAM.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load                  capture load_addr/load_data, buffer becomes full
//   load_addr, load_data  write to be posted
//   retire                buffered write was written to RAM this cycle
//   full                  buffer holds a write not yet in RAM
//   addr, data            buffered write
// ----------------------------------------------------------------------------
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              retire,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;

    // Buffer entry: load sets it, retire clears it (never both in one cycle)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            addr_r  <= load_addr;
            data_r  <= load_data;
        end else if (retire) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign full = valid_r;
    assign addr = addr_r;
    assign data = data_r;

endmodule : vram_wbuf

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM between the pixel fetcher and the
// CPU. Video has absolute priority; the CPU is served in cycles without a
// video request and may starve under continuous video traffic.
// Ports:
//   clk     system (pixel) clock
//   reset   asynchronous active-high reset
//   bus     vram_arbiter_if.slave: video, CPU and RAM buses
// Build option:
//   VRAM_WRITE_BUFFER_EN  adds a one-entry posted-write buffer (vram_wbuf);
//                         CPU writes are acked without waiting for video
//                         gaps, reads wait until the buffer has drained.
// ----------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int STALL_W = VRAM_STALL_W
) (
    input  logic           clk,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);

    localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0] STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_SAT  = {STALL_W{1'b1}};

    cpu_state_e         state_r;
    logic               vid_valid_r;
    logic               cpu_ack_r;
    logic               ack_rd_r;
    logic [STALL_W-1:0] stall_r;

    logic               cpu_pending_s;
    logic               cpu_go_s;
    logic               cpu_mem_s;

    function automatic logic [STALL_W-1:0] stall_inc(input logic [STALL_W-1:0] v);
        if (v == STALL_SAT) begin
            return v;
        end else begin
            return v + STALL_ONE;
        end
    endfunction

`ifdef VRAM_WRITE_BUFFER_EN
    logic              wb_load_s;
    logic              wb_retire_s;
    logic              wb_full_s;
    logic [ADDR_W-1:0] wb_addr_s;
    logic [DATA_W-1:0] wb_data_s;

    // The buffer drains into any cycle video leaves free, ahead of new CPU issues
    assign wb_retire_s = !reset && wb_full_s && !bus.vid_req;

    vram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .load      (wb_load_s),
        .load_addr (bus.cpu_addr),
        .load_data (bus.cpu_wdata),
        .retire    (wb_retire_s),
        .full      (wb_full_s),
        .addr      (wb_addr_s),
        .data      (wb_data_s)
    );
`endif

    // Decide whether the pending CPU access completes this cycle and whether it uses the RAM port
    always_comb begin
        cpu_pending_s = 1'b0;
        cpu_go_s      = 1'b0;
        cpu_mem_s     = 1'b0;
`ifdef VRAM_WRITE_BUFFER_EN
        wb_load_s     = 1'b0;
`endif
        if (reset) begin
            cpu_pending_s = 1'b0;
            cpu_go_s      = 1'b0;
            cpu_mem_s     = 1'b0;
        end else begin
            // ACK never issues, so a request still held there is not served twice
            cpu_pending_s = ((state_r == ST_IDLE) && bus.cpu_req) || (state_r == ST_ISSUE);
`ifdef VRAM_WRITE_BUFFER_EN
            if (bus.cpu_we) begin
                // Posted write: only needs a free buffer slot, not a free RAM cycle
                cpu_go_s  = cpu_pending_s && !wb_full_s;
                wb_load_s = cpu_go_s;
                cpu_mem_s = 1'b0;
            end else begin
                // Read waits for the buffer to drain to keep read-after-write order
                cpu_go_s  = cpu_pending_s && !wb_full_s && !bus.vid_req;
                wb_load_s = 1'b0;
                cpu_mem_s = cpu_go_s;
            end
`else
            cpu_go_s  = cpu_pending_s && !bus.vid_req;
            cpu_mem_s = cpu_go_s;
`endif
        end
    end

    // RAM port mux: video first, then buffered write, then CPU; idle cycles park on the video address
    always_comb begin
        bus.mem_addr  = bus.vid_addr;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = bus.cpu_wdata;
        if (reset) begin
            bus.mem_addr  = bus.vid_addr;
            bus.mem_we    = 1'b0;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (bus.vid_req) begin
            bus.mem_addr  = bus.vid_addr;
            bus.mem_we    = 1'b0;
            bus.mem_wdata = bus.cpu_wdata;
`ifdef VRAM_WRITE_BUFFER_EN
        end else if (wb_retire_s) begin
            bus.mem_addr  = wb_addr_s;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = wb_data_s;
`endif
        end else if (cpu_mem_s) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_we    = bus.cpu_we;
            bus.mem_wdata = bus.cpu_wdata;
        end else begin
            bus.mem_addr  = bus.vid_addr;
            bus.mem_we    = 1'b0;
            bus.mem_wdata = bus.cpu_wdata;
        end
    end

    // Video pipeline: RAM data appears one cycle after the fetch address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid_r <= 1'b0;
        end else begin
            vid_valid_r <= bus.vid_req;
        end
    end

    // CPU access FSM: sequencing, ack pulse and saturating stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cpu_ack_r <= 1'b0;
            ack_rd_r  <= 1'b0;
            stall_r   <= STALL_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_go_s) begin
                        state_r   <= ST_ACK;
                        cpu_ack_r <= 1'b1;
                        ack_rd_r  <= !bus.cpu_we;
                        stall_r   <= STALL_ZERO;
                    end else if (bus.cpu_req) begin
                        // Counter restarts for the new request and counts this blocked cycle
                        state_r   <= ST_ISSUE;
                        cpu_ack_r <= 1'b0;
                        ack_rd_r  <= 1'b0;
                        stall_r   <= STALL_ONE;
                    end else begin
                        state_r   <= ST_IDLE;
                        cpu_ack_r <= 1'b0;
                        ack_rd_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (cpu_go_s) begin
                        state_r   <= ST_ACK;
                        cpu_ack_r <= 1'b1;
                        ack_rd_r  <= !bus.cpu_we;
                    end else begin
                        state_r   <= ST_ISSUE;
                        cpu_ack_r <= 1'b0;
                        ack_rd_r  <= 1'b0;
                        stall_r   <= stall_inc(stall_r);
                    end
                end
                ST_ACK: begin
                    state_r   <= ST_IDLE;
                    cpu_ack_r <= 1'b0;
                    ack_rd_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cpu_ack_r <= 1'b0;
                    ack_rd_r  <= 1'b0;
                    stall_r   <= STALL_ZERO;
                end
            endcase
        end
    end

    // RAM read data is forwarded only in the cycle it belongs to; zero otherwise
    assign bus.vid_valid = vid_valid_r;
    assign bus.vid_data  = vid_valid_r ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_rdata = (cpu_ack_r && ack_rd_r) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.cpu_stall = stall_r;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural 16K x 8 synchronous RAM
// preloaded with ram[a] = a[7:0]. A per-cycle vector table covers video-only
// fetches, CPU write/read and video/CPU contention; hand-written sequences
// cover stall saturation, asynchronous reset mid-access and, when
// VRAM_WRITE_BUFFER_EN is defined, the posted-write buffer.
// ----------------------------------------------------------------------------
module tb_vram_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    vram_arbiter_if #(.ADDR_W(14), .DATA_W(8), .STALL_W(8)) bus ();

    vram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: preload on the first edge, then 1-cycle read latency
    logic [7:0] ram [0:16383];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int a = 0; a < 16384; a++) ram[a] <= a[7:0];
            ram_loaded <= 1'b1;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

`ifdef VRAM_WRITE_BUFFER_EN
    localparam logic T5_WE = 1'b0;
`else
    localparam logic T5_WE = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vr, input logic [13:0] va, input logic cr,
                         input logic cw, input logic [13:0] ca, input logic [7:0] cd);
        bus.vid_req   = vr;
        bus.vid_addr  = va;
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
    endtask

`ifndef VRAM_WRITE_BUFFER_EN
    typedef struct {
        logic       vr;  logic [13:0] va;
        logic       cr;  logic cw; logic [13:0] ca; logic [7:0] cd;
        logic       mwe; logic [13:0] maddr;
        logic       vv;  logic [7:0] vd;
        logic       ack; logic ck_rd; logic [7:0] rd;
        logic [7:0] st;
    } vec_t;

    function automatic vec_t mk(input logic vr, input logic [13:0] va, input logic cr,
                                input logic cw, input logic [13:0] ca, input logic [7:0] cd,
                                input logic mwe, input logic [13:0] maddr, input logic vv,
                                input logic [7:0] vd, input logic ack, input logic ck_rd,
                                input logic [7:0] rd, input logic [7:0] st);
        vec_t v;
        v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.mwe = mwe; v.maddr = maddr; v.vv = vv; v.vd = vd;
        v.ack = ack; v.ck_rd = ck_rd; v.rd = rd; v.st = st;
        return v;
    endfunction
`endif

    initial begin
`ifndef VRAM_WRITE_BUFFER_EN
        vec_t vecs[$];
`endif
        drive(1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 8'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_vid_valid", {31'd0, bus.vid_valid}, 32'd0);
        chk("reset_vid_data",  {24'd0, bus.vid_data},  32'd0);
        chk("reset_cpu_ack",   {31'd0, bus.cpu_ack},   32'd0);
        chk("reset_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        chk("reset_cpu_stall", {24'd0, bus.cpu_stall}, 32'd0);
        chk("reset_mem_we",    {31'd0, bus.mem_we},    32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifndef VRAM_WRITE_BUFFER_EN
        //               vr    va       cr    cw    ca       cd     | mwe  maddr    vv    vd     ack  ckrd  rd     stall
        // video only
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b1, 14'h100, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b1, 14'h101, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h101, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b1, 14'h102, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h102, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b1, 14'h103, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h103, 1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        // CPU write 0x2A@0x040 (req held into ACK, not re-served), then read back
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b1, 14'h040, 8'h2A, 1'b1, 14'h040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b1, 14'h040, 8'h2A, 1'b0, 14'h000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b0, 14'h040, 8'h00, 1'b0, 14'h040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h2A, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        // contention: video 5 cycles, CPU read of 0x041 waits
        vecs.push_back(mk(1'b1, 14'h110, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h110, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b1, 14'h111, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h111, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'd1));
        vecs.push_back(mk(1'b1, 14'h112, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h112, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'd2));
        vecs.push_back(mk(1'b1, 14'h113, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h113, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 8'd3));
        vecs.push_back(mk(1'b1, 14'h114, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h114, 1'b1, 8'h13, 1'b0, 1'b0, 8'h00, 8'd4));
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b0, 14'h041, 8'h00, 1'b0, 14'h041, 1'b1, 8'h14, 1'b0, 1'b0, 8'h00, 8'd5));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 8'd5));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd5));
        // unblocked write clears the stall count; read it back
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b1, 14'h050, 8'hA5, 1'b1, 14'h050, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd5));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b1, 1'b0, 14'h050, 8'h00, 1'b0, 14'h050, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 8'd0));
        vecs.push_back(mk(1'b0, 14'h000, 1'b0, 1'b0, 14'h000, 8'h00, 1'b0, 14'h000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0));

        foreach (vecs[i]) begin
            drive(vecs[i].vr, vecs[i].va, vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
            #1;
            chk($sformatf("v%0d_mem_we", i),    {31'd0, bus.mem_we},    {31'd0, vecs[i].mwe});
            chk($sformatf("v%0d_mem_addr", i),  {18'd0, bus.mem_addr},  {18'd0, vecs[i].maddr});
            chk($sformatf("v%0d_vid_valid", i), {31'd0, bus.vid_valid}, {31'd0, vecs[i].vv});
            if (vecs[i].vv) chk($sformatf("v%0d_vid_data", i), {24'd0, bus.vid_data}, {24'd0, vecs[i].vd});
            chk($sformatf("v%0d_cpu_ack", i),   {31'd0, bus.cpu_ack},   {31'd0, vecs[i].ack});
            if (vecs[i].ck_rd) chk($sformatf("v%0d_cpu_rdata", i), {24'd0, bus.cpu_rdata}, {24'd0, vecs[i].rd});
            chk($sformatf("v%0d_cpu_stall", i), {24'd0, bus.cpu_stall}, {24'd0, vecs[i].st});
            @(negedge clk);
        end
`endif

        // Stall saturation: 300 blocked cycles, read of 0x042 pending
        drive(1'b1, 14'h140, 1'b1, 1'b0, 14'h042, 8'h00);
        for (int k = 0; k < 300; k++) begin
            #1;
            if (k == 254) chk("sat_stall_254", {24'd0, bus.cpu_stall}, 32'd254);
            if (k == 299) chk("sat_stall_held", {24'd0, bus.cpu_stall}, 32'd255);
            @(negedge clk);
        end
        bus.vid_req = 1'b0;
        #1;
        chk("sat_issue_addr", {18'd0, bus.mem_addr}, 32'h042);
        chk("sat_no_ack_yet", {31'd0, bus.cpu_ack}, 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("sat_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("sat_rdata", {24'd0, bus.cpu_rdata}, 32'h42);
        chk("sat_stall_final", {24'd0, bus.cpu_stall}, 32'd255);
        @(negedge clk);
        #1;
        chk("sat_ack_pulse", {31'd0, bus.cpu_ack}, 32'd0);
        @(negedge clk);

        // Async reset while the CPU access is blocked in ISSUE
        drive(1'b1, 14'h120, 1'b1, T5_WE, 14'h060, 8'h77);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pre_stall", {24'd0, bus.cpu_stall}, 32'd3);
        chk("rst_pre_vvalid", {31'd0, bus.vid_valid}, 32'd1);
        #1;
        bus.vid_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_cpu_stall", {24'd0, bus.cpu_stall}, 32'd0);
        chk("rst_vid_valid", {31'd0, bus.vid_valid}, 32'd0);
        chk("rst_vid_data", {24'd0, bus.vid_data}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
        @(negedge clk);
        drive(1'b0, 14'h000, 1'b0, 1'b0, 14'h070, 8'h00);
        chk("rst_write_dropped", {24'd0, ram[14'h060]}, 32'h60);
        reset = 1'b0;
        #1;
        chk("rst_idle_addr", {18'd0, bus.mem_addr}, 32'h000);
        chk("rst_idle_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_no_ack_1", {31'd0, bus.cpu_ack}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_no_ack_2", {31'd0, bus.cpu_ack}, 32'd0);
        drive(1'b0, 14'h000, 1'b1, 1'b0, 14'h060, 8'h00);
        #1;
        chk("rst_after_issue", {18'd0, bus.mem_addr}, 32'h060);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("rst_after_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("rst_after_rdata", {24'd0, bus.cpu_rdata}, 32'h60);
        @(negedge clk);

`ifdef VRAM_WRITE_BUFFER_EN
        // Posted write during video, then a read that must wait for the drain
        drive(1'b1, 14'h130, 1'b1, 1'b1, 14'h010, 8'h55);
        #1;
        chk("wb_load_no_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("wb_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("wb_ack_stall", {24'd0, bus.cpu_stall}, 32'd0);
        @(negedge clk);
        drive(1'b1, 14'h131, 1'b1, 1'b0, 14'h010, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("wb_hold_ack_%0d", k), {31'd0, bus.cpu_ack}, 32'd0);
            chk($sformatf("wb_hold_we_%0d", k), {31'd0, bus.mem_we}, 32'd0);
            @(negedge clk);
        end
        bus.vid_req = 1'b0;
        #1;
        chk("wb_retire_we", {31'd0, bus.mem_we}, 32'd1);
        chk("wb_retire_addr", {18'd0, bus.mem_addr}, 32'h010);
        chk("wb_retire_data", {24'd0, bus.mem_wdata}, 32'h55);
        @(negedge clk);
        #1;
        chk("wb_read_addr", {18'd0, bus.mem_addr}, 32'h010);
        chk("wb_read_we", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
        chk("wb_read_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("wb_read_rdata", {24'd0, bus.cpu_rdata}, 32'h55);
        chk("wb_read_stall", {24'd0, bus.cpu_stall}, 32'd5);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_vram_arbiter
